day1_mux_arbiter: RTL and testbench
===================================

Name: day1_mux_arbiter

Overview:
Round-robin arbiter that shares the team's 8-bit 2:1 mux (day1) between two requesters, A and B.
- Grants one requester at a time and drives the mux select.
- Registers the mux output into a one-deep valid/ready output stage.
- Bounds burst length so neither requester can starve the other.
- Sits between two producer channels and a single downstream 8-bit consumer.

Parameters:
- MAX_BURST, 4, max consecutive transfers one requester may make while the other is requesting (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- a_req_i  input  1  A has a beat (valid); held until granted
- a_data_i  input  8  A data
- a_gnt_o  output  1  A beat accepted this cycle (ready)
- b_req_i  input  1  B has a beat (valid); held until granted
- b_data_i  input  8  B data
- b_gnt_o  output  1  B beat accepted this cycle (ready)
- sel_o  output  1  current mux select; 1 = A, 0 = B
- y_valid_o  output  1  output beat valid
- y_data_o  output  8  output beat data
- y_ready_i  input  1  downstream accepts beat

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, last_owner=B (so A wins the first tie), burst_cnt=0.
  - a_gnt_o=0, b_gnt_o=0, sel_o=0, y_valid_o=0, y_data_o=8'h00.
  - An in-flight beat is dropped; no output is produced until a new grant.
- States: IDLE, GRANT_A, GRANT_B (registered). sel_o=1 iff state==GRANT_A.
- out_free = !y_valid_o || y_ready_i.
- Grant outputs (combinational from state/regs/inputs):
  - a_gnt_o = (state==GRANT_A) && out_free && !(b_req_i && burst_cnt==MAX_BURST).
  - b_gnt_o is symmetric.
- Transfer on the owner channel = req && gnt.
  - On a transfer: y_data_o <= mux output (the granted channel's data), y_valid_o <= 1. Latency is 1 cycle from transfer to y_valid_o.
  - Otherwise, if y_ready_i: y_valid_o <= 0; y_data_o holds.
  - Full throughput: 1 beat/cycle while out_free.
- IDLE transitions:
  - both req → grant the requester != last_owner.
  - only A → GRANT_A; only B → GRANT_B; none → stay.
  - No grant is asserted in IDLE, so the first beat arrives at the earliest 2 cycles after req.
- GRANT_X, with O = the other requester:
  - burst_cnt increments on each X transfer and saturates at MAX_BURST.
  - Switch to GRANT_O when O_req && (!X_req || burst_cnt==MAX_BURST).
  - Go to IDLE when !X_req && !O_req.
  - On any state change: burst_cnt <= 0; last_owner <= X.
  - Otherwise stay.
- Switching inserts exactly one cycle with no grant (the grant is gated off when the limit is hit; the new state takes effect the next cycle).
- If O is not requesting, X may exceed MAX_BURST indefinitely (burst_cnt stays saturated).
- Downstream stall (y_valid_o=1, y_ready_i=0):
  - Both gnts are 0; y_data_o and y_valid_o hold.
  - State and burst_cnt hold unless a switch/idle condition fires.
- Requester protocol: req_i must stay high with stable data until granted. A deasserted req without a grant is treated as withdrawal.
- Never: both gnts high; gnt high in IDLE; y_data_o changing while y_valid_o && !y_ready_i.

Decomposition:
- Package day1_arb_pkg:
  - DATA_W=8.
  - typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t.
  - typedef enum logic {OWNER_B=0, OWNER_A=1} owner_t.
- Sub-module: instantiate the existing day1 mux for the datapath.
  - a_i=a_data_i, b_i=b_data_i, sel_i=sel_o, feeding the output register.
  - No new datapath sub-module.

Test Plan:
- Reset, then a_req_i=1 with A data 8'h11,8'h22,8'h33, b_req_i=0, y_ready_i=1:
  - a_gnt_o first high 1 cycle after req.
  - y_data_o = 11,22,33 on consecutive cycles; sel_o=1.
- Both req from IDLE with A=8'hA0.., B=8'hB0.., MAX_BURST=4, y_ready_i=1:
  - Output is A0..A3, one idle cycle, then B0..B3, one idle cycle, then A4.
  - Never 5 consecutive beats from one side.
- Only B requesting, 10 beats: all 10 pass back-to-back with no forced switch.
  - Assert a_req_i mid-burst: B stops at burst_cnt==4 and GRANT_A follows.
- Output stall: during A transfers hold y_ready_i=0 for 3 cycles with y_data_o=8'h22:
  - y_data_o stays 8'h22, y_valid_o=1, a_gnt_o=0.
  - Release: next beat 8'h33 follows with no loss or duplication.
- Tie after A owned last (A drops, both re-request from IDLE): B granted first.
  - Repeat: grants alternate.
- Assert reset_n=0 mid-burst with y_valid_o=1:
  - All outputs are 0 immediately (async).
  - After release with both req, A is granted first.

Source files
------------

// File: rtl/day1_arb_pkg.sv
// Shared types for the day1 mux arbiter.
// Data width, arbiter state and last-owner encodings.
package day1_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_A,
    GRANT_B
  } arb_state_t;

  typedef enum logic {
    OWNER_B = 1'b0,
    OWNER_A = 1'b1
  } owner_t;

endpackage

// File: rtl/day1_mux.sv
// Team 2:1 mux, W bits wide.
// a_i/b_i: data in; sel_i: 1 = a_i; y_o: selected data.
module day1_mux #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? a_i : b_i;

endmodule

// File: rtl/day1_mux_arbiter.sv
// Round-robin, burst-limited arbiter for two producers over day1_mux.
// Ports: a/b req+data in, a/b gnt out, sel_o, y valid/ready/data out.
module day1_mux_arbiter
  import day1_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_gnt_o,
  input  logic              b_req_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_gnt_o,
  output logic              sel_o,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  input  logic              y_ready_i
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  arb_state_t        state_q;
  arb_state_t        state_d;
  owner_t            last_q;
  owner_t            last_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              at_max;
  logic              out_free;
  logic              a_xfer;
  logic              b_xfer;
  logic [DATA_W-1:0] mux_y;

  assign at_max   = (cnt_q == BURST_MAX);
  assign out_free = !y_valid_o || y_ready_i;
  assign sel_o    = (state_q == GRANT_A);

  // Owner is cut off once its burst hits the
  // limit while the other side is waiting.
  assign a_gnt_o = (state_q == GRANT_A)
                && out_free
                && !(b_req_i && at_max);
  assign b_gnt_o = (state_q == GRANT_B)
                && out_free
                && !(a_req_i && at_max);

  assign a_xfer = a_req_i && a_gnt_o;
  assign b_xfer = b_req_i && b_gnt_o;

  day1_mux #(
    .W(DATA_W)
  ) u_mux (
    .a_i  (a_data_i),
    .b_i  (b_data_i),
    .sel_i(sel_o),
    .y_o  (mux_y)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (a_req_i && b_req_i) begin
          state_d = (last_q == OWNER_B)
                  ? GRANT_A : GRANT_B;
        end else if (a_req_i) begin
          state_d = GRANT_A;
        end else if (b_req_i) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (b_req_i && (!a_req_i || at_max)) begin
          state_d = GRANT_B;
          cnt_d   = '0;
          last_d  = OWNER_A;
        end else if (!a_req_i && !b_req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = OWNER_A;
        end else if (a_xfer && !at_max) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GRANT_B: begin
        if (a_req_i && (!b_req_i || at_max)) begin
          state_d = GRANT_A;
          cnt_d   = '0;
          last_d  = OWNER_B;
        end else if (!a_req_i && !b_req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = OWNER_B;
        end else if (b_xfer && !at_max) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= OWNER_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_valid_o <= 1'b0;
      y_data_o  <= '0;
    end else if (a_xfer || b_xfer) begin
      y_valid_o <= 1'b1;
      y_data_o  <= mux_y;
    end else if (y_ready_i) begin
      y_valid_o <= 1'b0;
    end
  end

  a_one_gnt: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(a_gnt_o && b_gnt_o));

  a_idle_gnt: assert property (
    @(posedge clk) disable iff (!reset_n)
    (state_q == IDLE) |-> !(a_gnt_o || b_gnt_o));

  a_stall_hold: assert property (
    @(posedge clk) disable iff (!reset_n)
    (y_valid_o && !y_ready_i)
      |=> (y_valid_o && $stable(y_data_o)));

endmodule

// File: tb/tb_day1_mux_arbiter.sv
// Self-checking bench for day1_mux_arbiter.
// Directed plan scenarios, then random traffic vs. a reference model.
module tb_day1_mux_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_req;
  logic [7:0] a_data;
  logic       a_gnt;
  logic       b_req;
  logic [7:0] b_data;
  logic       b_gnt;
  logic       sel;
  logic       y_valid;
  logic [7:0] y_data;
  logic       y_ready;

  always #5 clk = ~clk;

  day1_mux_arbiter #(
    .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_req_i  (a_req),
    .a_data_i (a_data),
    .a_gnt_o  (a_gnt),
    .b_req_i  (b_req),
    .b_data_i (b_data),
    .b_gnt_o  (b_gnt),
    .sel_o    (sel),
    .y_valid_o(y_valid),
    .y_data_o (y_data),
    .y_ready_i(y_ready)
  );

  logic [7:0] aq[$];
  logic [7:0] bq[$];
  int         trace[$];
  int         checks = 0;
  int         errors = 0;
  logic       s_ag;
  logic       s_bg;

  // Reference: owner 0=none 1=A 2=B,
  // last winner 1=A 0=B, run = beats in burst.
  int         m_own;
  int         m_last;
  int         m_run;
  logic       m_yv;
  logic [7:0] m_yd;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    a_req  = (aq.size() != 0);
    a_data = a_req ? aq[0] : 8'h00;
    b_req  = (bq.size() != 0);
    b_data = b_req ? bq[0] : 8'h00;
  endtask

  task automatic model_reset();
    m_own  = 0;
    m_last = 0;
    m_run  = 0;
    m_yv   = 1'b0;
    m_yd   = 8'h00;
  endtask

  // Called at posedge+1; returns at next posedge+1.
  task automatic tick();
    logic       ar, br, yr, ea, eb, free, xa, xb;
    logic [7:0] ad, bd;
    #3;
    ar   = a_req;
    br   = b_req;
    yr   = y_ready;
    ad   = a_data;
    bd   = b_data;
    free = !m_yv || yr;
    ea   = (m_own == 1) && free
        && !(br && m_run >= MB);
    eb   = (m_own == 2) && free
        && !(ar && m_run >= MB);
    check("a_gnt", a_gnt, ea);
    check("b_gnt", b_gnt, eb);
    check("sel", sel, m_own == 1);
    s_ag = a_gnt;
    s_bg = b_gnt;
    xa   = ar && ea;
    xb   = br && eb;
    @(posedge clk);
    #1;
    if (xa) begin
      m_yv = 1'b1;
      m_yd = ad;
    end else if (xb) begin
      m_yv = 1'b1;
      m_yd = bd;
    end else if (yr) begin
      m_yv = 1'b0;
    end
    if (m_own == 0) begin
      if (ar && br) m_own = (m_last == 1) ? 2 : 1;
      else if (ar) m_own = 1;
      else if (br) m_own = 2;
    end else begin
      logic mine, other;
      mine  = (m_own == 1) ? ar : br;
      other = (m_own == 1) ? br : ar;
      if (other && (!mine || m_run >= MB)) begin
        m_last = (m_own == 1) ? 1 : 0;
        m_own  = (m_own == 1) ? 2 : 1;
        m_run  = 0;
      end else if (!mine && !other) begin
        m_last = (m_own == 1) ? 1 : 0;
        m_own  = 0;
        m_run  = 0;
      end else if ((xa || xb) && m_run < MB) begin
        m_run++;
      end
    end
    check("y_valid", y_valid, m_yv);
    check("y_data", y_data, m_yd);
    trace.push_back(y_valid ? int'(y_data) : -1);
    if (ar && s_ag) void'(aq.pop_front());
    if (br && s_bg) void'(bq.pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    aq.delete();
    bq.delete();
    drive();
    y_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    trace.delete();
  endtask

  task automatic expect_trace(input string tag,
                              input int e[$]);
    for (int i = 0; i < e.size(); i++) begin
      check(tag,
            (i < trace.size()) ? trace[i] : -2,
            e[i]);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    y_ready = 1'b1;
    while ((aq.size() != 0 || bq.size() != 0
            || y_valid) && n < 100) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 100, 1);
    tick();
    trace.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int e[$];
    reset_n = 1'b0;
    aq.delete();
    bq.delete();
    drive();
    y_ready = 1'b1;
    model_reset();
    #2;
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_sel", sel, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data", y_data, 0);
    do_reset();

    // A only, three beats.
    aq = '{8'h11, 8'h22, 8'h33};
    drive();
    tick();
    check("t1_idle_gnt", s_ag, 0);
    tick();
    check("t1_first_gnt", s_ag, 1);
    check("t1_sel", sel, 1);
    tick();
    tick();
    e = '{-1, 'h11, 'h22, 'h33};
    expect_trace("t1_trace", e);
    drain();

    // Both request, burst limit alternation.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      aq.push_back(8'hA0 + 8'(i));
      bq.push_back(8'hB0 + 8'(i));
    end
    drive();
    repeat (12) tick();
    e = '{-1, 'hA0, 'hA1, 'hA2, 'hA3, -1,
          'hB0, 'hB1, 'hB2, 'hB3, -1, 'hA4};
    expect_trace("t2_rr", e);
    drain();

    // B only, ten beats back to back.
    for (int i = 0; i < 10; i++)
      bq.push_back(8'hC0 + 8'(i));
    drive();
    repeat (11) tick();
    e = '{-1, 'hC0, 'hC1, 'hC2, 'hC3, 'hC4,
          'hC5, 'hC6, 'hC7, 'hC8, 'hC9};
    expect_trace("t3_long", e);
    drain();

    // A arrives mid B burst.
    for (int i = 0; i < 10; i++)
      bq.push_back(8'hD0 + 8'(i));
    drive();
    repeat (7) tick();
    aq = '{8'hE0, 8'hE1};
    drive();
    repeat (5) tick();
    e = '{-1, 'hD0, 'hD1, 'hD2, 'hD3, 'hD4,
          'hD5, -1, 'hE0, 'hE1, -1, 'hD6};
    expect_trace("t3_cut", e);
    drain();

    // Output stall.
    aq = '{8'h11, 8'h22, 8'h33};
    drive();
    repeat (3) tick();
    y_ready = 1'b0;
    repeat (3) begin
      tick();
      check("t4_stall_gnt", s_ag, 0);
      check("t4_stall_data", y_data, 8'h22);
      check("t4_stall_valid", y_valid, 1);
    end
    y_ready = 1'b1;
    repeat (2) tick();
    e = '{-1, 'h11, 'h22, 'h22, 'h22, 'h22,
          'h33, -1};
    expect_trace("t4_trace", e);
    drain();

    // Ties after A owned last.
    aq = '{8'h51};
    bq = '{8'h61};
    drive();
    repeat (4) tick();
    e = '{-1, 'h61, -1, 'h51};
    expect_trace("t5_tie1", e);
    drain();
    aq = '{8'h52};
    bq = '{8'h62};
    drive();
    repeat (4) tick();
    e = '{-1, 'h62, -1, 'h52};
    expect_trace("t5_tie2", e);
    drain();

    // Async reset mid burst.
    for (int i = 0; i < 8; i++)
      aq.push_back(8'h71 + 8'(i));
    drive();
    repeat (3) tick();
    check("t6_pre_valid", y_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_a_gnt", a_gnt, 0);
    check("t6_b_gnt", b_gnt, 0);
    check("t6_sel", sel, 0);
    check("t6_y_valid", y_valid, 0);
    check("t6_y_data", y_data, 0);
    aq.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    aq = '{8'h81};
    bq = '{8'h91};
    drive();
    trace.delete();
    repeat (2) tick();
    e = '{-1, 'h81};
    expect_trace("t6_after", e);
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      int pa, pb;
      pa = ((c / 250) % 2 == 1) ? 2 : 10;
      pb = ((c / 330) % 2 == 1) ? 2 : 10;
      if (aq.size() < 6 && $urandom_range(15) < pa)
        aq.push_back(8'($urandom));
      if (bq.size() < 6 && $urandom_range(15) < pb)
        bq.push_back(8'($urandom));
      y_ready = ($urandom_range(3) != 0);
      drive();
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
